// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment display path: blank pattern, hex glyph
// table (active-low, bit 0 = segment a) and default scan timing.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int DEF_REFRESH_BITS = 17;
  localparam int DEF_GUARD        = 1024;

  // Entry n is the glyph for nibble n; the first element listed is nibble F.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/mod_hex7seg.sv
// Combinational nibble to active-low gfedcba segment decoder.
module mod_hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/mod_display_mux.sv
// Scanned common-anode 7-segment driver with frame-aligned double buffering
// and optional leading-zero blanking.
module mod_display_mux
  import disp_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_BITS = DEF_REFRESH_BITS,
  parameter int GUARD        = DEF_GUARD
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic                    loaded,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [REFRESH_BITS-1:0] CNT_MAX   = {REFRESH_BITS{1'b1}};
  localparam logic [REFRESH_BITS-1:0] GUARD_CNT = REFRESH_BITS'(GUARD);
  localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [REFRESH_BITS-1:0] cnt;
  logic [IDX_W-1:0]        idx;
  logic                    slot_wrap;
  logic                    frame_end;

  logic [4*N_DIGITS-1:0]   pend_value;
  logic [N_DIGITS-1:0]     pend_dp;
  logic                    pend;
  logic [4*N_DIGITS-1:0]   shadow_value;
  logic [N_DIGITS-1:0]     shadow_dp;

  logic [N_DIGITS-1:0]     blanked;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;
  logic                    cur_dp;
  logic                    cur_blank;

  assign slot_wrap = (cnt == CNT_MAX);
  assign frame_end = slot_wrap && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Commit takes the buffer as registered before this edge, so a load on the
  // boundary cycle lands in the pending buffer and waits for the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_value   <= '0;
      pend_dp      <= '0;
      pend         <= 1'b0;
      shadow_value <= '0;
      shadow_dp    <= '0;
    end else begin
      if (frame_end && pend) begin
        shadow_value <= pend_value;
        shadow_dp    <= pend_dp;
        pend         <= 1'b0;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp_mask;
        pend       <= 1'b1;
      end
    end
  end

  // A digit is blanked when it and every digit to its left are zero.
  always_comb begin
    blanked  = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_value[4*i +: 4] == 4'h0);
      if (i != 0) begin
        blanked[i] = lz_blank & zero_run;
      end
    end
  end

  assign cur_nib   = shadow_value[{idx, 2'b00} +: 4];
  assign cur_dp    = shadow_dp[idx];
  assign cur_blank = blanked[idx];

  mod_hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      loaded     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      loaded     <= frame_end && pend;
      frame_tick <= frame_end;
      if ((cnt < GUARD_CNT) || cur_blank) begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(N_DIGITS'(1) << idx);
        seg <= cur_seg;
        dp  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_mod_display_mux.sv
// Randomised bench for mod_display_mux against a cycle-count based model of
// the scan, blanking and frame-commit rules.
module tb_mod_display_mux;

  localparam int N     = 4;
  localparam int RB    = 4;
  localparam int GRD   = 2;
  localparam int SLOT  = 16;
  localparam int FRAME = SLOT * N;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic        loaded;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int          vectors = 0;
  int          miscompares = 0;

  // Model state: cycles since reset release, pending and displayed data.
  int          t = 0;
  bit          pend = 0;
  logic [15:0] pbuf_v = '0;
  logic [3:0]  pbuf_m = '0;
  logic [15:0] shadow_v = '0;
  logic [3:0]  shadow_m = '0;

  mod_display_mux #(.N_DIGITS(N), .REFRESH_BITS(RB), .GUARD(GRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_mask    (dp_mask),
    .lz_blank   (lz_blank),
    .load       (load),
    .loaded     (loaded),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_an"}, 32'(an), 32'hF);
    checkOutput({tag, "_seg"}, 32'(seg), 32'h7F);
    checkOutput({tag, "_dp"}, 32'(dp), 32'h1);
    checkOutput({tag, "_loaded"}, 32'(loaded), 32'h0);
    checkOutput({tag, "_ftick"}, 32'(frame_tick), 32'h0);
  endtask

  // One clock: predict the registered outputs from the pre-edge model state,
  // advance the model, then compare shortly after the edge.
  task automatic step();
    int          c;
    int          d;
    bit          bnd;
    logic [15:0] sh;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_ld;
    logic        e_ft;
    @(posedge clk);
    c   = t % SLOT;
    d   = (t / SLOT) % N;
    bnd = (c == SLOT - 1) && (d == N - 1);
    sh  = shadow_v >> (4 * d);
    if (c < GRD || (lz_blank && d > 0 && sh == 16'h0)) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = 4'hF & ~(4'b0001 << d);
      e_seg = hex_seg(sh[3:0]);
      e_dp  = ~shadow_m[d];
    end
    e_ld = bnd && pend;
    e_ft = bnd;
    if (bnd && pend) begin
      shadow_v = pbuf_v;
      shadow_m = pbuf_m;
      pend     = 0;
    end
    if (load) begin
      pbuf_v = value;
      pbuf_m = dp_mask;
      pend   = 1;
    end
    t++;
    #1;
    checkOutput("an", 32'(an), 32'(e_an));
    checkOutput("seg", 32'(seg), 32'(e_seg));
    checkOutput("dp", 32'(dp), 32'(e_dp));
    checkOutput("loaded", 32'(loaded), 32'(e_ld));
    checkOutput("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic applyStimulus(input bit ld, input logic [15:0] v, input logic [3:0] m);
    load    = ld;
    value   = v;
    dp_mask = m;
    step();
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, value, dp_mask);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) applyStimulus(1'b0, value, dp_mask);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic mid_cycle_reset();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    t        = 0;
    pend     = 0;
    pbuf_v   = '0;
    pbuf_m   = '0;
    shadow_v = '0;
    shadow_m = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_outputs("in_rst");
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] rv;
    int          lead;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    idle(130);

    wait_phase(20);
    applyStimulus(1'b1, 16'h12AF, 4'b0100);
    idle(140);

    lz_blank = 1'b1;
    applyStimulus(1'b1, 16'h0050, 4'b0000);
    idle(140);
    applyStimulus(1'b1, 16'h0000, 4'b1111);
    idle(140);
    lz_blank = 1'b0;

    wait_phase(5);
    applyStimulus(1'b1, 16'h1111, 4'b0001);
    idle(7);
    applyStimulus(1'b1, 16'h2222, 4'b0010);
    idle(140);

    wait_phase(FRAME - 1);
    applyStimulus(1'b1, 16'h3333, 4'b1000);
    idle(140);

    wait_phase(30);
    applyStimulus(1'b1, 16'h4444, 4'b1111);
    idle(10);
    mid_cycle_reset();
    idle(140);

    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        rv   = 16'($urandom);
        lead = $urandom_range(0, 4);
        rv   = (lead == 4) ? 16'h0 : (rv & (16'hFFFF >> (4 * lead)));
        applyStimulus(1'b1, rv, 4'($urandom));
      end else begin
        applyStimulus(1'b0, 16'($urandom), 4'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_display_mux.md
Name: mod_display_mux

Overview:
Time-multiplexed driver for the calculator's common-anode 7-segment display bank. It takes a packed hex/BCD value and decimal-point mask from the core, scans one digit at a time, and drives active-low anode and segment pins. Updates are double-buffered and committed only at frame boundaries, so a display never shows a half-updated value. It is the output-side counterpart to the button front end: clean core data goes in, physical pin waveforms come out.

Parameters:
N_DIGITS, 8, number of digits scanned (2..8).
REFRESH_BITS, 17, width of per-digit slot counter; slot = 2^REFRESH_BITS cycles.
GUARD, 1024, cycles at the start of each slot with all anodes off (anti-ghosting); must be < 2^REFRESH_BITS.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-low.
value  in  4*N_DIGITS  digit nibbles; nibble i = value[4i+3:4i]; digit 0 is rightmost.
dp_mask  in  N_DIGITS  1 = light the decimal point of digit i.
lz_blank  in  1  1 = blank leading zero digits; live input, not buffered.
load  in  1  single-cycle strobe; captures value and dp_mask into the pending buffer.
loaded  out  1  single-cycle pulse when pending data is committed to the display.
an  out  N_DIGITS  anodes, active-low, at most one bit low.
seg  out  7  segments, active-low; seg[0]=a .. seg[6]=g.
dp  out  1  decimal point, active-low.
frame_tick  out  1  single-cycle pulse at every frame boundary.

Behaviour:
- Reset (rst=0, async): an all 1, seg=7'h7F, dp=1, loaded=0, frame_tick=0. Slot counter, digit index, pending flag, pending buffer and shadow buffer all cleared. The first frame after reset displays 0, or only digit 0 when lz_blank=1.
- Slot counter cnt: free-running, 0..2^REFRESH_BITS-1, wraps to 0.
- Digit index idx: increments on cnt wrap; wraps from N_DIGITS-1 to 0.
- Frame boundary: cycle where cnt wraps and idx = N_DIGITS-1.
- Scan outputs are registered, one cycle latency from (cnt, idx):
  - If cnt < GUARD, or digit idx is blanked: an all 1, seg=7'h7F, dp=1.
  - Otherwise: an[idx]=0 with all other anode bits 1; seg = hex7seg(shadow nibble idx); dp = ~shadow_dp[idx].
- Blanking rule: with lz_blank=1, digit i (i>0) is blanked iff shadow nibbles N_DIGITS-1 down to i are all zero. Digit 0 is never blanked. A blanked digit's dp is also suppressed.
- Hex encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Load handshake:
  - load=1 writes value and dp_mask into the pending buffer and sets the pending flag.
  - A second load before commit overwrites the buffer; last write wins.
- Commit: at a frame boundary with pending=1, shadow <= pending buffer, pending flag cleared, and loaded=1 on the next cycle, aligned with frame_tick.
- Simultaneous load and frame boundary:
  - Commit uses the previously registered pending data, if any.
  - The new data lands in the pending buffer with the flag set, and commits at the next boundary.
- frame_tick pulses every frame regardless of pending, registered one cycle after the boundary.
- Reset mid-frame: all state is lost, including un-committed pending data, and outputs return to reset values immediately.

Decomposition:
- Package disp_pkg: SEG_BLANK=7'h7F constant, the hex-to-segment constant table, and localparams for the default REFRESH_BITS and GUARD.
- Sub-module mod_hex7seg: purely combinational nibble-to-seg decoder, instantiated once on the selected nibble.

Test Plan:
Use N_DIGITS=4, REFRESH_BITS=4, GUARD=2 for all scenarios.
1. Reset release, no load -> an=4'b1111 for cycles with cnt<2; then an=4'b1110, seg=7'b1000000 (shows "0000"); frame_tick every 64 cycles.
2. load with value=16'h12AF, dp_mask=4'b0100 mid-frame -> shadow unchanged until boundary; loaded coincides with frame_tick. Next frame: digit0 seg=0001110, digit1 0001000, digit2 0100100 with dp=0, digit3 1111001.
3. lz_blank=1, value=16'h0050 -> digits 3 and 2 keep an high for the whole slot; digits 1 and 0 show 5 and 0. Then value=16'h0000 -> only digit 0 lit.
4. Two loads (16'h1111, then 16'h2222) in the same frame -> a single loaded pulse; display shows 2222, never 1111.
5. load asserted on the exact boundary cycle with pending=0 -> no commit that frame (loaded=0); commit and loaded at the following boundary.
6. rst asserted mid-slot with pending=1 -> an=4'b1111, seg=7'h7F, dp=1 asynchronously; after release, display shows 0000 and loaded never pulses.
